frame_buffer_arbiter: RTL and testbench

FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

---
 rtl/frame_buffer_arbiter_pkg.sv | 48 ++++
 rtl/frame_buffer_arbiter_if.sv | 44 ++++
 rtl/frame_buffer_arbiter_wr_fifo.sv | 80 ++++++++
 rtl/frame_buffer_arbiter.sv | 154 +++++++++++++++
 tb/tb_frame_buffer_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_buffer_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fb_pkg
// Description : Shared types and constants for the frame buffer arbiter:
//               canvas geometry, colour type and palette, brush-queue entry
//               layout and the arbiter state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

  localparam int COORD_MAX = 128;   // canvas is COORD_MAX x COORD_MAX
  localparam int ADDR_W    = 14;    // {y[6:0], x[6:0]}
  localparam int COLOR_W   = 3;
  localparam int COORD_W   = 10;

  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t BLACK   = 3'd0;
  localparam color_t BLUE    = 3'd1;
  localparam color_t GREEN   = 3'd2;
  localparam color_t CYAN    = 3'd3;
  localparam color_t RED     = 3'd4;
  localparam color_t MAGENTA = 3'd5;
  localparam color_t YELLOW  = 3'd6;
  localparam color_t WHITE   = 3'd7;
  localparam color_t ERASE   = WHITE;  // blank-canvas colour

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // 23-bit brush-queue entry: {x[6:0], y[6:0], pad[5:0], color[2:0]}
  typedef struct packed {
    logic [6:0] x;
    logic [6:0] y;
    logic [5:0] pad;
    color_t     color;
  } wr_entry_t;

  // True when a 10-bit coordinate lies on the canvas (< COORD_MAX).
  function automatic logic coord_ok(input logic [COORD_W-1:0] c);
    return (c[COORD_W-1:7] == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_buffer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : frame_buffer_arbiter_if
// Description : Bundles the VGA read port, brush write handshake, clear
//               control and frame-RAM port of the frame buffer arbiter.
// Modports    : slave  - arbiter view (drives rd_color, wr_ready, RAM port)
//               master - environment view (drives coordinates, requests,
//                        ram_rdata)
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_buffer_arbiter_if;
  import fb_pkg::*;

  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;
  color_t             rd_color;
  logic               wr_valid;
  logic               wr_ready;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  color_t             wr_color;
  logic               clear_req;
  logic               clear_busy;
  logic [7:0]         drop_cnt;
  logic [ADDR_W-1:0]  ram_addr;
  logic               ram_re;
  logic               ram_we;
  color_t             ram_wdata;
  color_t             ram_rdata;

  modport slave (
    input  rd_x, rd_y, wr_valid, wr_x, wr_y, wr_color, clear_req, ram_rdata,
    output rd_color, wr_ready, clear_busy, drop_cnt,
           ram_addr, ram_re, ram_we, ram_wdata
  );

  modport master (
    output rd_x, rd_y, wr_valid, wr_x, wr_y, wr_color, clear_req, ram_rdata,
    input  rd_color, wr_ready, clear_busy, drop_cnt,
           ram_addr, ram_re, ram_we, ram_wdata
  );

endinterface
`default_nettype wire

// File: rtl/frame_buffer_arbiter_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wr_fifo
// Description : Brush-write queue. Power-of-two depth circular buffer with
//               synchronous flush; simultaneous push and pop keeps occupancy.
// Ports       : clk, reset (async active-low)
//               flush_i      - discard all entries (wins over push/pop)
//               push_i/push_data_i - enqueue (ignored when full)
//               pop_i        - dequeue head (ignored when empty)
//               head_o       - oldest entry
//               empty_o/full_o - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module wr_fifo
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush_i,
  input  logic      push_i,
  input  wr_entry_t push_data_i,
  input  logic      pop_i,
  output wr_entry_t head_o,
  output logic      empty_o,
  output logic      full_o
);

  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  wr_entry_t        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   cnt_q,  cnt_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == FULL_CNT);
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;
  assign head_o    = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (w_do_push) wptr_d = wptr_q + 1'b1;
      if (w_do_pop)  rptr_d = rptr_q + 1'b1;
      if (w_do_push && !w_do_pop)      cnt_d = cnt_q + 1'b1;
      else if (!w_do_push && w_do_pop) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush_i) mem_q[wptr_q] <= push_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/frame_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : frame_buffer_arbiter
// Description : Time-multiplexes a single-port 128x128x3 frame RAM between a
//               VGA reader (even cycles) and a brush writer / canvas clear
//               engine (odd cycles). Brush writes are queued in wr_fifo;
//               off-canvas writes are dropped and counted.
// Ports       : clk   - system clock
//               reset - asynchronous active-low reset
//               bus   - frame_buffer_arbiter_if.slave (read port, write
//                       handshake, clear control, drop counter, RAM port)
// Revision    : 1.0 - initial release
// ============================================================================
module frame_buffer_arbiter
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  frame_buffer_arbiter_if.slave bus
);

  logic              phase_q;        // 0 = read slot, 1 = write slot
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clear_addr_q, clear_addr_d;
  logic              rd_oor_q;       // read-slot coordinate was off canvas
  color_t            rd_color_q, rd_color_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  wr_entry_t         w_push_entry;
  wr_entry_t         w_head;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_wr_ready;
  logic              w_accept;
  logic              w_wr_on_canvas;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic              w_flush;
  logic              w_pad_unused;

  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_re;
  logic              w_ram_we;
  color_t            w_ram_wdata;

  // ---------------------------------------------------------------- brush queue
  // wr_ready is gated by reset so the handshake is closed while held in reset.
  assign w_wr_ready     = reset && (state_q == IDLE) && !w_fifo_full && !bus.clear_req;
  assign w_accept       = bus.wr_valid && w_wr_ready;
  assign w_wr_on_canvas = coord_ok(bus.wr_x) && coord_ok(bus.wr_y);
  assign w_push         = w_accept && w_wr_on_canvas;
  assign w_drop         = w_accept && !w_wr_on_canvas;
  assign w_pop          = phase_q && (state_q == IDLE) && !w_fifo_empty;
  assign w_flush        = (state_q == IDLE) && bus.clear_req;

  assign w_push_entry = '{x: bus.wr_x[6:0], y: bus.wr_y[6:0], pad: '0, color: bus.wr_color};
  assign w_pad_unused = ^w_head.pad;

  wr_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (w_flush),
    .push_i      (w_push),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .empty_o     (w_fifo_empty),
    .full_o      (w_fifo_full)
  );

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d      = CLEAR;
          clear_addr_d = '0;
        end
      end
      CLEAR: begin
        if (phase_q) begin
          clear_addr_d = clear_addr_q + 1'b1;
          if (clear_addr_q == '1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RAM port
  always_comb begin
    w_ram_re    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = {bus.rd_y[6:0], bus.rd_x[6:0]};
    w_ram_wdata = ERASE;
    if (reset) begin
      if (!phase_q) begin
        w_ram_re = 1'b1;
      end else if (state_q == CLEAR) begin
        w_ram_we   = 1'b1;
        w_ram_addr = clear_addr_q;
      end else if (!w_fifo_empty) begin
        w_ram_we    = 1'b1;
        w_ram_addr  = {w_head.y, w_head.x};
        w_ram_wdata = w_head.color;
      end
    end
  end

  // ---------------------------------------------------------------- read data / drop count
  // ram_rdata is valid during the write slot that follows a read slot.
  always_comb begin
    rd_color_d = rd_color_q;
    if (phase_q) rd_color_d = rd_oor_q ? ERASE : bus.ram_rdata;
    drop_cnt_d = drop_cnt_q;
    if (w_drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q      <= 1'b0;
      state_q      <= IDLE;
      clear_addr_q <= '0;
      rd_oor_q     <= 1'b0;
      rd_color_q   <= ERASE;
      drop_cnt_q   <= '0;
    end else begin
      phase_q      <= ~phase_q;
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      if (!phase_q) rd_oor_q <= !(coord_ok(bus.rd_x) && coord_ok(bus.rd_y));
      rd_color_q   <= rd_color_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign bus.rd_color   = rd_color_q;
  assign bus.wr_ready   = w_wr_ready;
  assign bus.clear_busy = (state_q == CLEAR);
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.ram_addr   = w_ram_addr;
  assign bus.ram_re     = w_ram_re;
  assign bus.ram_we     = w_ram_we;
  assign bus.ram_wdata  = w_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buffer_arbiter
// Description : Self-checking bench for frame_buffer_arbiter. A behavioural
//               frame RAM answers reads; accepted on-canvas brush writes are
//               queued as expected RAM writes and a monitor pops/compares
//               every RAM write the arbiter issues.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frame_buffer_arbiter;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frame_buffer_arbiter_if bus();

  frame_buffer_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;   // cycles since reset release; even = read slot

  typedef struct packed {
    logic [13:0] addr;
    color_t      color;
  } wexp_t;

  wexp_t exp_q[$];
  wexp_t mon_e;
  bit    clr_mode = 1'b0;
  int    clr_cnt  = 0;

  // ---------------------------------------------------------------- RAM model
  function automatic color_t init_pat(input logic [13:0] a);
    return a[2:0] + a[9:7];
  endfunction

  bit     seen [16384];
  color_t wmem [16384];
  always @(posedge clk) begin
    if (bus.ram_we === 1'b1) begin
      wmem[bus.ram_addr] <= bus.ram_wdata;
      seen[bus.ram_addr] <= 1'b1;
    end
    if (bus.ram_re === 1'b1)
      bus.ram_rdata <= seen[bus.ram_addr] ? wmem[bus.ram_addr] : init_pat(bus.ram_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- write monitor
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.ram_we === 1'b1) begin
      check("we_excludes_re", 32'(bus.ram_re), 32'd0);
      if (clr_mode) begin
        check("clear_addr", 32'(bus.ram_addr), 32'(clr_cnt[13:0]));
        check("clear_data", 32'(bus.ram_wdata), 32'(ERASE));
        clr_cnt++;
      end else if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data %0d, expected no write", bus.ram_addr, bus.ram_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.ram_addr), 32'(mon_e.addr));
        check("wr_data", 32'(bus.ram_wdata), 32'(mon_e.color));
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic align_read();
    while (cyc[0] != 1'b0) tick();
  endtask

  task automatic do_read(input logic [9:0] x, input logic [9:0] y, input color_t exp, input string nm);
    align_read();
    bus.rd_x = x;
    bus.rd_y = y;
    tick();
    tick();
    check(nm, 32'(bus.rd_color), 32'(exp));
  endtask

  task automatic push(input logic [9:0] x, input logic [9:0] y, input color_t c, output int stalls);
    bit acc;
    acc        = 1'b0;
    stalls     = 0;
    bus.wr_valid = 1'b1;
    bus.wr_x     = x;
    bus.wr_y     = y;
    bus.wr_color = c;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = bus.wr_ready;
      if (!acc) stalls++;
      tick();
    end
    if (!acc) begin
      n_assert++;
      n_fail++;
      $display("FAIL push_timeout: wr_ready stayed 0, expected acceptance");
    end else if (x < 10'd128 && y < 10'd128) begin
      exp_q.push_back({y[6:0], x[6:0], c});
    end
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    check(nm, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int st;
    int tot;
    int busy;
    int flushed;

    reset         = 1'b1;
    bus.rd_x      = 10'd5;
    bus.rd_y      = 10'd7;
    bus.wr_valid  = 1'b0;
    bus.wr_x      = '0;
    bus.wr_y      = '0;
    bus.wr_color  = '0;
    bus.clear_req = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_color", 32'(bus.rd_color), 32'(ERASE));
    check("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check("rst_ram_re", 32'(bus.ram_re), 32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_clear_busy", 32'(bus.clear_busy), 32'd0);

    // First cycle after release is a read slot at {7,5} = 0x385.
    @(posedge clk);
    #1 reset = 1'b1;
    cyc = 0;
    @(negedge clk);
    check("first_ram_re", 32'(bus.ram_re), 32'd1);
    check("first_ram_addr", 32'(bus.ram_addr), 32'h385);
    check("first_ram_we", 32'(bus.ram_we), 32'd0);
    check("ready_after_rst", 32'(bus.wr_ready), 32'd1);
    tick();
    check("rd_color_hold_1edge", 32'(bus.rd_color), 32'(ERASE));
    @(negedge clk);
    check("write_slot_re", 32'(bus.ram_re), 32'd0);
    tick();
    check("rd_color_2edges", 32'(bus.rd_color), 32'd4);

    // Read path: off-canvas coordinates force ERASE.
    do_read(10'd3, 10'd130, ERASE, "rd_y130_erase");
    do_read(10'd3, 10'd2, 3'd5, "rd_in_range_same_addr");
    do_read(10'd127, 10'd127, 3'd6, "rd_corner");
    do_read(10'd128, 10'd0, ERASE, "rd_x128_erase");
    do_read(10'd0, 10'd0, 3'd0, "rd_origin");

    // Back-to-back burst: FIFO fills after the 7th accept (pops every other cycle).
    align_read();
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      push(10'(10 + i), 10'(20 + 2 * i), 3'(i), st);
      tot += st;
    end
    bus.wr_valid = 1'b0;
    check("burst_stalls", 32'(tot), 32'd1);
    drain("burst_drain");

    // Off-canvas writes are dropped and counted, saturating at 255.
    push(10'd200, 10'd5, RED, st);
    bus.wr_valid = 1'b0;
    repeat (4) tick();
    check("drop_cnt_1", 32'(bus.drop_cnt), 32'd1);
    for (int i = 0; i < 300; i++) push(10'd300, 10'd900, BLUE, st);
    bus.wr_valid = 1'b0;
    tick();
    check("drop_cnt_sat", 32'(bus.drop_cnt), 32'd255);
    push(10'd5, 10'd128, GREEN, st);
    push(10'd127, 10'd0, MAGENTA, st);
    bus.wr_valid = 1'b0;
    tick();
    check("drop_cnt_hold", 32'(bus.drop_cnt), 32'd255);
    drain("edge_write_drain");

    // Clear with C,D,E queued: C pops in the clear_req slot, D,E are flushed.
    align_read();
    push(10'd1, 10'd1, RED, st);
    push(10'd2, 10'd1, GREEN, st);
    push(10'd3, 10'd1, BLUE, st);
    push(10'd4, 10'd1, CYAN, st);
    push(10'd5, 10'd1, YELLOW, st);
    bus.wr_valid  = 1'b0;
    bus.clear_req = 1'b1;
    @(negedge clk);
    check("ready_low_clear_req", 32'(bus.wr_ready), 32'd0);
    tick();
    bus.clear_req = 1'b0;
    flushed = exp_q.size();
    check("queued_at_clear", 32'(flushed), 32'd2);
    exp_q.delete();
    clr_mode = 1'b1;
    clr_cnt  = 0;
    busy     = 0;
    for (int k = 0; k < 40000; k++) begin
      @(negedge clk);
      if (bus.clear_busy !== 1'b1) break;
      busy++;
      if (k == 100) bus.clear_req = 1'b1;   // ignored while clearing
      if (k == 101) bus.clear_req = 1'b0;
      tick();
    end
    tick();
    check("clear_busy_cycles", 32'(busy), 32'd32768);
    check("clear_write_count", 32'(clr_cnt), 32'd16384);
    clr_mode = 1'b0;
    repeat (10) tick();
    check("idle_after_clear", 32'(bus.clear_busy), 32'd0);
    check("ready_after_clear", 32'(bus.wr_ready), 32'd1);
    do_read(10'd5, 10'd7, ERASE, "rd_after_clear");

    // Reset asserted mid-clear at clear_addr = 1000.
    while (cyc[0] != 1'b1) tick();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    clr_mode = 1'b1;
    clr_cnt  = 0;
    for (int k = 0; k < 5000 && clr_cnt < 1000; k++) tick();
    check("clear_progress", 32'(clr_cnt), 32'd1000);
    #2 reset = 1'b0;
    #1;
    check("abort_ram_we", 32'(bus.ram_we), 32'd0);
    check("abort_clear_busy", 32'(bus.clear_busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("abort_ram_we_held", 32'(bus.ram_we), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc = 0;
    clr_mode = 1'b0;
    repeat (6) tick();
    check("post_abort_busy", 32'(bus.clear_busy), 32'd0);
    check("post_abort_ready", 32'(bus.wr_ready), 32'd1);
    check("post_abort_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    check("no_clear_writes_after_abort", 32'(clr_cnt), 32'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
